fpu_denorm_sched: RTL and testbench

Shared, multi-cycle denorm/zero classifier for the FPU. Two requesters (e.g. add and mul pipes) contend through a round-robin arbiter for one 3-bit slice-compare cell. The scheduler latches the winner's operand pair and walks it MSB-first, one 3-bit slice per cycle. It returns a non-zero flag and a denorm flag (din2's leading one at or above din1's) tagged with the requester id.

---
 rtl/fpu_denorm_sched_if.sv | 33 +++
 rtl/fpu_denorm_sched.sv | 137 +++++++++++++
 tb/tb_fpu_denorm_sched.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/fpu_denorm_sched_if.sv
// Requester/result bundle for fpu_denorm_sched.
// The master side is the requesters and result consumer; the slave side is the scheduler.
interface fpu_denorm_sched_if #(
    parameter int WIDTH = 54
);
    logic             req0_vld;
    logic [WIDTH-1:0] req0_din1;
    logic [WIDTH-1:0] req0_din2;
    logic             req0_ack;
    logic             req1_vld;
    logic [WIDTH-1:0] req1_din1;
    logic [WIDTH-1:0] req1_din2;
    logic             req1_ack;
    logic             res_vld;
    logic             res_id;
    logic             res_nz;
    logic             res_denorm;
    logic             busy;

    modport master (
        output req0_vld, req0_din1, req0_din2,
        output req1_vld, req1_din1, req1_din2,
        input  req0_ack, req1_ack,
        input  res_vld, res_id, res_nz, res_denorm, busy
    );

    modport slave (
        input  req0_vld, req0_din1, req0_din2,
        input  req1_vld, req1_din1, req1_din2,
        output req0_ack, req1_ack,
        output res_vld, res_id, res_nz, res_denorm, busy
    );
endinterface

// File: rtl/fpu_denorm_sched.sv
// Two-requester round-robin scheduler around a shared 3-bit slice-compare cell.
// Define FPU_DENORM_SCHED_EARLY_EXIT_EN to stop the MSB-first scan at the first non-zero slice.
module fpu_denorm_sched #(
    parameter int WIDTH = 54
) (
    input logic             rclk,
    input logic             arst_l,
    fpu_denorm_sched_if.slave bus
);
    localparam int NSLICE = WIDTH / 3;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_din1;
    logic [WIDTH-1:0]   r_din2;
    logic               r_id;
    logic               r_found;
    logic               r_denorm;
    logic               r_last_grant;
    logic               r_ack0;
    logic               r_ack1;
    logic               r_res_vld;
    logic               r_res_id;
    logic               r_res_nz;
    logic               r_res_denorm;
    logic               r_busy;

    logic [2:0]         w_a;
    logic [2:0]         w_b;
    logic [2:0]         w_z;
    logic               w_nz;
    logic               w_dn;
    logic               w_last;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_found_nxt;
    logic               w_denorm_nxt;

    assign w_a  = r_din1[3*r_idx +: 3];
    assign w_b  = r_din2[3*r_idx +: 3];
    assign w_z  = ~(w_a | w_b);
    assign w_nz = ~&w_z;
    assign w_dn = w_b[2] | (w_z[2] & w_b[1]) | (w_z[2] & w_z[1] & w_b[0]);

    // The first non-zero slice from the MSB decides the denorm flag; later slices are ignored.
    assign w_found_nxt  = r_found | w_nz;
    assign w_denorm_nxt = r_found ? r_denorm : w_dn;

`ifdef FPU_DENORM_SCHED_EARLY_EXIT_EN
    assign w_last = (r_idx == '0) || w_nz;
`else
    assign w_last = (r_idx == '0);
`endif

    // On a tie, the requester not granted last time wins.
    assign w_gnt0 = (r_state == ST_IDLE) && bus.req0_vld && (!bus.req1_vld || r_last_grant);
    assign w_gnt1 = (r_state == ST_IDLE) && bus.req1_vld && (!bus.req0_vld || !r_last_grant);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_gnt0 || w_gnt1) w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            r_idx        <= IDX_W'(NSLICE - 1);
            r_din1       <= '0;
            r_din2       <= '0;
            r_id         <= 1'b0;
            r_found      <= 1'b0;
            r_denorm     <= 1'b0;
            r_last_grant <= 1'b1;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_res_vld    <= 1'b0;
            r_res_id     <= 1'b0;
            r_res_nz     <= 1'b0;
            r_res_denorm <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_ack0    <= w_gnt0;
            r_ack1    <= w_gnt1;
            r_res_vld <= (r_state == ST_SCAN) && w_last;
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_din1       <= w_gnt1 ? bus.req1_din1 : bus.req0_din1;
                        r_din2       <= w_gnt1 ? bus.req1_din2 : bus.req0_din2;
                        r_id         <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        r_idx        <= IDX_W'(NSLICE - 1);
                        r_found      <= 1'b0;
                        r_denorm     <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_found  <= w_found_nxt;
                    r_denorm <= w_denorm_nxt;
                    if (w_last) begin
                        r_res_id     <= r_id;
                        r_res_nz     <= w_found_nxt;
                        r_res_denorm <= w_found_nxt & w_denorm_nxt;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ack   = r_ack0;
    assign bus.req1_ack   = r_ack1;
    assign bus.res_vld    = r_res_vld;
    assign bus.res_id     = r_res_id;
    assign bus.res_nz     = r_res_nz;
    assign bus.res_denorm = r_res_denorm;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_fpu_denorm_sched.sv
// Directed self-checking bench for fpu_denorm_sched at WIDTH=54 (NSLICE=18).
module tb_fpu_denorm_sched;
    localparam int W = 54;

    logic rclk;
    logic arst_l;
    int   n_checks;
    int   n_errors;

    fpu_denorm_sched_if #(.WIDTH(W)) u_if ();

    fpu_denorm_sched #(.WIDTH(W)) u_dut (
        .rclk   (rclk),
        .arst_l (arst_l),
        .bus    (u_if.slave)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic int lat(input int early_k);
`ifdef FPU_DENORM_SCHED_EARLY_EXIT_EN
        return early_k;
`else
        return 18 + 0 * early_k;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {57'd0, u_if.req0_ack, u_if.req1_ack, u_if.res_vld, u_if.res_id,
                             u_if.res_nz, u_if.res_denorm, u_if.busy}, 64'd0);
    endtask

    task automatic start(input int id, input logic [W-1:0] d1, input logic [W-1:0] d2);
        @(negedge rclk);
        if (id == 0) begin
            u_if.req0_vld = 1'b1; u_if.req0_din1 = d1; u_if.req0_din2 = d2;
        end else begin
            u_if.req1_vld = 1'b1; u_if.req1_din1 = d1; u_if.req1_din2 = d2;
        end
    endtask

    // Samples cycle 1 after the capture edge and releases the granted request.
    task automatic expect_ack(input string tag, input int id);
        @(posedge rclk); #1;
        chk({tag, "_ack0"}, {63'd0, u_if.req0_ack}, (id == 0) ? 64'd1 : 64'd0);
        chk({tag, "_ack1"}, {63'd0, u_if.req1_ack}, (id == 1) ? 64'd1 : 64'd0);
        chk({tag, "_busy"}, {63'd0, u_if.busy}, 64'd1);
        if (id == 0) u_if.req0_vld = 1'b0;
        else         u_if.req1_vld = 1'b0;
    endtask

    task automatic expect_res(input string tag, input int id, input int k, input logic nz, input logic dn);
        int c;
        int stray_ack;
        stray_ack = 0;
        for (c = 2; c <= 40; c++) begin
            @(posedge rclk); #1;
            if (u_if.req0_ack || u_if.req1_ack) stray_ack++;
            if (u_if.res_vld) break;
        end
        chk({tag, "_latency"}, 64'(c), 64'(k + 1));
        chk({tag, "_no_ack"}, 64'(stray_ack), 64'd0);
        chk({tag, "_id"}, {63'd0, u_if.res_id}, 64'(id));
        chk({tag, "_nz"}, {63'd0, u_if.res_nz}, {63'd0, nz});
        chk({tag, "_dn"}, {63'd0, u_if.res_denorm}, {63'd0, dn});
        @(posedge rclk); #1;
        chk({tag, "_vld_pulse"}, {63'd0, u_if.res_vld}, 64'd0);
        chk({tag, "_idle"}, {63'd0, u_if.busy}, 64'd0);
        chk({tag, "_hold"}, {62'd0, u_if.res_nz, u_if.res_denorm}, {62'd0, nz, dn});
    endtask

    task automatic run_req(input string tag, input int id, input logic [W-1:0] d1, input logic [W-1:0] d2,
                           input int k, input logic nz, input logic dn);
        start(id, d1, d2);
        expect_ack(tag, id);
        expect_res(tag, id, k, nz, dn);
    endtask

    initial begin
        int stray;
        n_checks = 0;
        n_errors = 0;
        arst_l = 1'b0;
        u_if.req0_vld = 1'b0; u_if.req0_din1 = '0; u_if.req0_din2 = '0;
        u_if.req1_vld = 1'b0; u_if.req1_din1 = '0; u_if.req1_din2 = '0;
        repeat (3) @(posedge rclk);
        #1;
        chk_all_zero("reset");
        @(negedge rclk);
        arst_l = 1'b1;

        run_req("msb_din2", 0, 54'd0, 54'd1 << 53, lat(1), 1'b1, 1'b1);
        run_req("msb_din1", 0, 54'd1 << 53, 54'd1 << 52, lat(1), 1'b1, 1'b0);
        run_req("all_zero", 1, 54'd0, 54'd0, 18, 1'b0, 1'b0);
        run_req("lsb_only", 0, 54'd1, 54'd1, 18, 1'b1, 1'b1);
        // slice 10: a=011 b=001 -> din1 leads, not denorm; lower-slice din2 bit must not matter
        run_req("mid_slice", 1, 54'd3 << 30, (54'd1 << 30) | 54'd4, lat(8), 1'b1, 1'b0);

        // Tie from reset: req0 first, req1 in the IDLE after DONE, then a tie goes to req0 again.
        @(negedge rclk);
        arst_l = 1'b0;
        u_if.req0_vld = 1'b1; u_if.req0_din1 = '0; u_if.req0_din2 = 54'd1 << 53;
        u_if.req1_vld = 1'b1; u_if.req1_din1 = '0; u_if.req1_din2 = '0;
        @(negedge rclk);
        arst_l = 1'b1;
        expect_ack("tie1", 0);
        expect_res("tie1", 0, lat(1), 1'b1, 1'b1);
        chk("tie_idle_no_ack1", {63'd0, u_if.req1_ack}, 64'd0);
        expect_ack("tie2", 1);
        expect_res("tie2", 1, 18, 1'b0, 1'b0);
        start(0, 54'd1, 54'd1);
        u_if.req1_vld = 1'b1; u_if.req1_din1 = '0; u_if.req1_din2 = '0;
        expect_ack("tie3", 0);
        u_if.req1_vld = 1'b0;
        expect_res("tie3", 0, 18, 1'b1, 1'b1);

        // Reset in SCAN cycle 5 of an all-zero scan, with a non-zero result still held.
        start(1, 54'd0, 54'd0);
        expect_ack("rst_scan", 1);
        repeat (4) @(posedge rclk);
        #1;
        chk("rst_scan_busy", {63'd0, u_if.busy}, 64'd1);
        arst_l = 1'b0;
        #1;
        chk_all_zero("rst_scan");
        @(negedge rclk);
        arst_l = 1'b1;
        stray = 0;
        repeat (25) begin
            @(posedge rclk); #1;
            if (u_if.res_vld || u_if.req0_ack || u_if.req1_ack || u_if.busy) stray++;
        end
        chk("rst_no_result", 64'(stray), 64'd0);
        run_req("reissue", 1, 54'd0, 54'd0, 18, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
